// File: rtl/ebi_pkg.sv
// Shared definitions for the 8-bit external bus: widths, strobe levels and
// the initiator's transaction states.
package ebi_pkg;

    localparam int EBI_ADDR_W = 8;
    localparam int EBI_DATA_W = 8;

    // CS/WR/RD are active low on the bus.
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_END    = 3'd3,
        ST_WAIT   = 3'd4,
        ST_TURN   = 3'd5
    } ebi_state_e;

endpackage

// File: rtl/ebi_clk_div.sv
// Bus clock generator: divides the system clock to CLK_bus and flags the
// system-clock cycle on which CLK_bus is about to rise or fall.
module ebi_clk_div #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic clk_bus,
    output logic bus_rise,
    output logic bus_fall
);

    localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_bus_q, clk_bus_d;
    logic             term;

    // Half-period counter; CLK_bus toggles on the terminal count.
    always_comb begin
        term      = (cnt_q == CNT_LAST);
        cnt_d     = term ? '0 : cnt_q + CNT_W'(1);
        clk_bus_d = term ? ~clk_bus_q : clk_bus_q;
    end

    // Divider state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            clk_bus_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_bus_q <= clk_bus_d;
        end
    end

    // Strobes are high in the cycle whose closing edge moves CLK_bus.
    assign bus_rise = term & ~clk_bus_q;
    assign bus_fall = term &  clk_bus_q;
    assign clk_bus  = clk_bus_q;

endmodule

// File: rtl/ebi_master.sv
// Initiator end of the 8-bit external bus. Single-beat host requests become
// CS/WR/RD strobe sequences; every bus pin moves only on a CLK_bus falling
// edge so the target sees half a bus period of setup and hold.
//
// Host handshake: a request is taken on any clock where req_valid && req_ready;
// req_ready is high only in IDLE with no request already held, so the request
// fields are ignored from the accepting clock until the block is IDLE again.
// rsp_valid is a single-clock pulse when the transaction completes.
module ebi_master
    import ebi_pkg::*;
#(
    parameter int HALF_DIV = 2,
    parameter int READ_LAT = 2,
    parameter int TURN_CYC = 1
) (
    input  logic                  CLK_50Mhz,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [EBI_ADDR_W-1:0] req_addr,
    input  logic [EBI_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [EBI_DATA_W-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  CLK_bus,
    output logic                  CS,
    output logic                  WR,
    output logic                  RD,
    output logic [EBI_ADDR_W-1:0] address,
    output logic [EBI_DATA_W-1:0] data_o,
    input  logic [EBI_DATA_W-1:0] data_i,
    output logic                  data_t,
    output ebi_state_e            dbg_state
);

    localparam int RC_W = $clog2(READ_LAT + 1);
    localparam int TC_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [RC_W-1:0] RISE_LAST = RC_W'(READ_LAT);
    localparam logic [TC_W-1:0] TURN_LAST = TC_W'(TURN_CYC - 1);

    logic bus_rise, bus_fall;

    ebi_state_e            state_q, state_d;
    logic                  pend_q, pend_d;
    logic                  wr_lat_q, wr_lat_d;
    logic [EBI_ADDR_W-1:0] addr_lat_q, addr_lat_d;
    logic [EBI_DATA_W-1:0] wdata_lat_q, wdata_lat_d;
    logic                  cs_q, cs_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [EBI_ADDR_W-1:0] addr_q, addr_d;
    logic [EBI_DATA_W-1:0] data_o_q, data_o_d;
    logic                  data_t_q, data_t_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [EBI_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [RC_W-1:0]       rise_cnt_q, rise_cnt_d;
    logic [TC_W-1:0]       turn_cnt_q, turn_cnt_d;
    logic                  accept;
    logic                  read_done;

    ebi_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_div (
        .clk      (CLK_50Mhz),
        .rst      (RST),
        .clk_bus  (CLK_bus),
        .bus_rise (bus_rise),
        .bus_fall (bus_fall)
    );

    // Host handshake, next-state and bus pin values.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        wr_lat_d    = wr_lat_q;
        addr_lat_d  = addr_lat_q;
        wdata_lat_d = wdata_lat_q;
        cs_d        = cs_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        data_o_d    = data_o_q;
        data_t_d    = data_t_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rise_cnt_d  = rise_cnt_q;
        turn_cnt_d  = turn_cnt_q;

        req_ready = (state_q == ST_IDLE) && !pend_q && !RST;
        accept    = req_valid && req_ready;

        // A read finishes on the fall after the READ_LAT-th rise since SETUP.
        read_done = bus_fall && (rise_cnt_q == RISE_LAST) &&
                    (((state_q == ST_SETUP) && !wr_lat_q) || (state_q == ST_WAIT));

        if (accept) begin
            pend_d      = 1'b1;
            wr_lat_d    = req_write;
            addr_lat_d  = req_addr;
            wdata_lat_d = req_wdata;
        end

        // Rises are counted while the read strobe is out.
        if (bus_rise && ((state_q == ST_SETUP) || (state_q == ST_WAIT)) &&
            (rise_cnt_q != RISE_LAST)) begin
            rise_cnt_d = rise_cnt_q + RC_W'(1);
        end

        if (bus_fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        pend_d     = 1'b0;
                        state_d    = ST_SETUP;
                        cs_d       = STROBE_ON;
                        wr_d       = STROBE_OFF;
                        addr_d     = addr_lat_q;
                        rise_cnt_d = '0;
                        if (wr_lat_q) begin
                            data_o_d = wdata_lat_q;
                            data_t_d = 1'b0;
                            rd_d     = STROBE_OFF;
                        end else begin
                            data_t_d = 1'b1;
                            rd_d     = STROBE_ON;
                        end
                    end
                end
                ST_SETUP: begin
                    if (wr_lat_q) begin
                        state_d = ST_STROBE;
                        wr_d    = STROBE_ON;
                    end else if (!read_done) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_STROBE: begin
                    state_d = ST_END;
                    wr_d    = STROBE_OFF;
                    cs_d    = STROBE_OFF;
                end
                ST_END: begin
                    state_d     = ST_TURN;
                    data_t_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    turn_cnt_d  = '0;
                end
                ST_WAIT: begin
                end
                ST_TURN: begin
                    if (turn_cnt_q == TURN_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        turn_cnt_d = turn_cnt_q + TC_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (read_done) begin
            state_d     = ST_TURN;
            rsp_rdata_d = data_i;
            rsp_valid_d = 1'b1;
            cs_d        = STROBE_OFF;
            rd_d        = STROBE_OFF;
            turn_cnt_d  = '0;
        end
    end

    // State and pin registers; reset releases the bus immediately.
    always_ff @(posedge CLK_50Mhz or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            wr_lat_q    <= 1'b0;
            addr_lat_q  <= '0;
            wdata_lat_q <= '0;
            cs_q        <= STROBE_OFF;
            wr_q        <= STROBE_OFF;
            rd_q        <= STROBE_OFF;
            addr_q      <= '0;
            data_o_q    <= '0;
            data_t_q    <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rise_cnt_q  <= '0;
            turn_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            wr_lat_q    <= wr_lat_d;
            addr_lat_q  <= addr_lat_d;
            wdata_lat_q <= wdata_lat_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            data_o_q    <= data_o_d;
            data_t_q    <= data_t_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rise_cnt_q  <= rise_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign CS        = cs_q;
    assign WR        = wr_q;
    assign RD        = rd_q;
    assign address   = addr_q;
    assign data_o    = data_o_q;
    assign data_t    = data_t_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ebi_master.sv
// Bench for ebi_master: two instances (default timing and a fast 25 MHz bus)
// each talking to a behavioural sync-RAM target clocked by its CLK_bus.
module tb_ebi_master;
    import ebi_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_write [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic       busy      [2];
    logic       clk_bus   [2];
    logic       cs        [2];
    logic       wr        [2];
    logic       rd        [2];
    logic [7:0] address   [2];
    logic [7:0] data_o    [2];
    logic       data_t    [2];
    ebi_state_e dbg_state [2];

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0] exp_q [2][$];

    typedef struct {
        int         u;
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;
    vec_t tbl [13];

    // clock
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int min);
        n_total++;
        if (act < min) begin
            n_bad++;
            $display("FAIL %s: got %0d want >= %0d", name, act, min);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int HD = (g == 0) ? 2 : 1;
        localparam int RL = (g == 0) ? 2 : 1;
        localparam int TC = (g == 0) ? 1 : 2;

        logic [7:0] ram [256];
        logic [7:0] pipe0, pipe1, tgt_out, bus_v;

        ebi_master #(
            .HALF_DIV (HD),
            .READ_LAT (RL),
            .TURN_CYC (TC)
        ) dut (
            .CLK_50Mhz (clk),
            .RST       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .busy      (busy[g]),
            .CLK_bus   (clk_bus[g]),
            .CS        (cs[g]),
            .WR        (wr[g]),
            .RD        (rd[g]),
            .address   (address[g]),
            .data_o    (data_o[g]),
            .data_i    (bus_v),
            .data_t    (data_t[g]),
            .dbg_state (dbg_state[g])
        );

        // shared bus wire: master drives when data_t=0, target when RD low, else pull-up
        assign tgt_out = (RL == 1) ? pipe0 : pipe1;
        assign bus_v   = !data_t[g] ? data_o[g] : (!rd[g] ? tgt_out : 8'hFF);

        initial begin
            for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hC3;
        end

        // target: sync RAM with READ_LAT-stage output pipe
        always @(posedge clk_bus[g]) begin
            if (!cs[g] && !wr[g]) ram[address[g]] <= bus_v;
            pipe0 <= ram[address[g]];
            pipe1 <= pipe0;
        end

        // scoreboard and pin-timing monitor
        int wr_lo, rd_lo, cs_hi, turn_n;
        bit cs_seen, turn_trk, prev_rv, prev_cs;
        logic [7:0] e;
        always @(negedge clk) begin
            if (rst) begin
                wr_lo = 0; rd_lo = 0; cs_hi = 0; turn_n = 0;
                cs_seen = 0; turn_trk = 0; prev_rv = 0; prev_cs = 1;
            end else begin
                chk($sformatf("u%0d_invariant cs=%b wr=%b rd=%b t=%b", g, cs[g], wr[g], rd[g], data_t[g]),
                    32'((!data_t[g] && !rd[g]) || (!wr[g] && !rd[g]) || (!wr[g] && cs[g])), 0);
                if (rsp_valid[g]) begin
                    chk($sformatf("u%0d_rsp_pulse_width", g), 32'(prev_rv), 0);
                    chk($sformatf("u%0d_rsp_expected", g), 32'(exp_q[g].size() != 0), 1);
                    if (exp_q[g].size() != 0) begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("u%0d_rsp_rdata", g), 32'(rsp_rdata[g]), 32'(e));
                    end
                    turn_trk = 1; turn_n = 1;
                end else if (turn_trk) begin
                    if (busy[g]) turn_n++;
                    else begin
                        chk($sformatf("u%0d_turn_clocks", g), turn_n, TC * 2 * HD);
                        turn_trk = 0;
                    end
                end
                prev_rv = rsp_valid[g];
                if (!wr[g]) wr_lo++;
                else if (wr_lo != 0) begin
                    chk($sformatf("u%0d_wr_low_clocks", g), wr_lo, 2 * HD);
                    wr_lo = 0;
                end
                if (!rd[g]) rd_lo++;
                else if (rd_lo != 0) begin
                    chk($sformatf("u%0d_rd_low_clocks", g), rd_lo, RL * 2 * HD);
                    rd_lo = 0;
                end
                if (cs[g]) cs_hi++;
                else if (prev_cs) begin
                    if (cs_seen) chk_ge($sformatf("u%0d_cs_high_gap", g), cs_hi, (TC + 1) * 2 * HD);
                    cs_seen = 1;
                    cs_hi = 0;
                end
                prev_cs = cs[g];
            end
        end
    end

    // driver: present a request and wait for it to be taken; req_valid stays high
    task automatic issue(input int un, input bit w, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] e);
        int n = 0;
        @(negedge clk);
        req_write[un] = w; req_addr[un] = a; req_wdata[un] = d; req_valid[un] = 1'b1;
        while (!req_ready[un] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("u%0d_accept_timeout", un), 32'(req_ready[un]), 1);
        if (req_ready[un]) begin
            exp_q[un].push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drop(input int un);
        @(negedge clk);
        req_valid[un] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || busy[0] || busy[1]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", 32'(exp_q[0].size() + exp_q[1].size()), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_reset_pins(input int un, input string tag);
        chk($sformatf("%s_u%0d_clk_bus", tag, un), 32'(clk_bus[un]), 0);
        chk($sformatf("%s_u%0d_cs", tag, un), 32'(cs[un]), 1);
        chk($sformatf("%s_u%0d_wr", tag, un), 32'(wr[un]), 1);
        chk($sformatf("%s_u%0d_rd", tag, un), 32'(rd[un]), 1);
        chk($sformatf("%s_u%0d_address", tag, un), 32'(address[un]), 0);
        chk($sformatf("%s_u%0d_data_o", tag, un), 32'(data_o[un]), 0);
        chk($sformatf("%s_u%0d_data_t", tag, un), 32'(data_t[un]), 1);
        chk($sformatf("%s_u%0d_req_ready", tag, un), 32'(req_ready[un]), 0);
        chk($sformatf("%s_u%0d_rsp_valid", tag, un), 32'(rsp_valid[un]), 0);
        chk($sformatf("%s_u%0d_rsp_rdata", tag, un), 32'(rsp_rdata[un]), 0);
        chk($sformatf("%s_u%0d_busy", tag, un), 32'(busy[un]), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // unit 0 (HALF_DIV=2, READ_LAT=2, TURN_CYC=1); RAM init is addr^0xC3
        tbl[0]  = '{0, 1'b1, 8'h3C, 8'hA5, 8'h00};
        tbl[1]  = '{0, 1'b0, 8'h3C, 8'h00, 8'hA5};
        tbl[2]  = '{0, 1'b1, 8'h00, 8'h11, 8'hA5};
        tbl[3]  = '{0, 1'b0, 8'hFF, 8'h00, 8'h3C};
        tbl[4]  = '{0, 1'b0, 8'h00, 8'h00, 8'h11};
        tbl[5]  = '{0, 1'b1, 8'h80, 8'h7E, 8'h11};
        tbl[6]  = '{0, 1'b0, 8'h80, 8'h00, 8'h7E};
        tbl[7]  = '{0, 1'b0, 8'h81, 8'h00, 8'h42};
        // unit 1 (HALF_DIV=1, READ_LAT=1, TURN_CYC=2)
        tbl[8]  = '{1, 1'b0, 8'h80, 8'h00, 8'h43};
        tbl[9]  = '{1, 1'b1, 8'h80, 8'h7E, 8'h43};
        tbl[10] = '{1, 1'b0, 8'h80, 8'h00, 8'h7E};
        tbl[11] = '{1, 1'b1, 8'h3C, 8'h5A, 8'h7E};
        tbl[12] = '{1, 1'b0, 8'h3C, 8'h00, 8'h5A};

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0;
            req_addr[i] = 8'h00; req_wdata[i] = 8'h00;
        end

        // reset
        rst = 1'b1;
        req_valid[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk_reset_pins(0, "por");
        chk_reset_pins(1, "por");
        req_valid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 32'(req_ready[0]), 1);

        // writes/reads back-to-back with req_valid held between them
        for (int i = 0; i < 8; i++) issue(tbl[i].u, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e);
        drop(0);
        drain();

        // request held while busy; fields changed mid-transaction must be ignored
        issue(0, 1'b1, 8'h10, 8'h99, 8'h42);
        req_write[0] = 1'b0; req_wdata[0] = 8'hEE;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t4_ready_low_while_busy", 32'(req_ready[0]), 0);
        end
        issue(0, 1'b0, 8'h10, 8'hEE, 8'h99);
        drop(0);
        drain();

        // reset pulse during read WAIT aborts with no response
        issue(0, 1'b0, 8'h3C, 8'h00, 8'hA5);
        drop(0);
        n = 0;
        while (dbg_state[0] != ST_WAIT && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_wait", 32'(dbg_state[0] == ST_WAIT), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_reset_pins(0, "abort");
        if (exp_q[0].size() != 0) void'(exp_q[0].pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(0, 1'b0, 8'h3C, 8'h00, 8'hA5);
        drop(0);
        drain();

        // fast bus instance
        for (int i = 8; i < 13; i++) issue(tbl[i].u, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e);
        drop(1);
        drain();

        // target RAM contents written over the bus
        chk("ram0_3c", 32'(u[0].ram[8'h3C]), 32'h A5);
        chk("ram0_00", 32'(u[0].ram[8'h00]), 32'h 11);
        chk("ram0_80", 32'(u[0].ram[8'h80]), 32'h 7E);
        chk("ram0_10", 32'(u[0].ram[8'h10]), 32'h 99);
        chk("ram1_80", 32'(u[1].ram[8'h80]), 32'h 7E);
        chk("ram1_3c", 32'(u[1].ram[8'h3C]), 32'h 5A);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
